nx_cdc_fifo_wr_arb: RTL and testbench

//  Shares the single write port of one nx_cdc_fifo instance between N requesters on the FIFO write clock.

---
 rtl/nx_cdc_fifo_wr_arb_pkg.sv | 12 +
 rtl/nx_cdc_fifo_wr_arb_rr_pick.sv | 32 +++
 rtl/nx_cdc_fifo_wr_arb.sv | 125 ++++++++++++
 tb/tb_nx_cdc_fifo_wr_arb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_cdc_fifo_wr_arb_pkg.sv
// Shared types and constants for the nx_cdc_fifo write-port arbiter and its round-robin picker.
package nx_cdc_fifo_wr_arb_typePKG;

    typedef enum logic {IDLE, LOCKED} wr_arb_state_e;

    localparam int STAT_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nx_cdc_fifo_wr_arb_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after the start pointer, wrapping.
module nx_rr_pick
    import nx_cdc_fifo_wr_arb_typePKG::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] winner,
    output logic          any
);

    int idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[IW'(idx)]) begin
                any    = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/nx_cdc_fifo_wr_arb.sv
// Round-robin, packet-locked arbiter sharing one nx_cdc_fifo write port among N_REQ producers.
// Per-requester packet counters are added when NX_FIFO_WR_ARB_STATS_EN is defined.
module nx_cdc_fifo_wr_arb
    import nx_cdc_fifo_wr_arb_typePKG::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int WIDTH  = 64,
    parameter  int DEPTH  = 16,
    localparam int ID_W   = idx_width(N_REQ),
    localparam int FREE_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0]  req_data,
    input  logic [N_REQ-1:0]             req_eop,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [FREE_W-1:0]            fifo_free,
    input  logic                         fifo_full,
    output logic                         fifo_wen,
    output logic [WIDTH-1:0]             fifo_wdata,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
`ifdef NX_FIFO_WR_ARB_STATS_EN
    ,
    input  logic                         stats_clr,
    output logic [N_REQ-1:0][STAT_W-1:0] grant_cnt
`endif
);

    wr_arb_state_e    state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic [ID_W-1:0]  sel_id;
    logic [N_REQ-1:0] ready_c;
    logic             credit_ok;
    logic             accept;
    logic             accept_eop;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == N_REQ - 1) ? '0 : id + ID_W'(1);
    endfunction

    // A beat sitting on fifo_wen is committed but not yet reflected in fifo_free, so it costs a slot.
    assign credit_ok = (fifo_free > FREE_W'(fifo_wen)) && !fifo_full;

    nx_rr_pick #(.N(N_REQ)) u_pick (
        .req    (req_valid),
        .start  (rr_ptr),
        .winner (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        ready_c = '0;
        sel_id  = pick_id;
        if (state == IDLE) begin
            if (pick_any && credit_ok) begin
                ready_c[pick_id] = 1'b1;
            end
        end else begin
            sel_id            = grant_id;
            ready_c[grant_id] = credit_ok;
        end
    end

    assign req_ready  = rst_n ? ready_c : '0;
    assign accept     = |(req_ready & req_valid);
    assign accept_eop = accept && req_eop[sel_id];

    // Lock is taken on a non-eop first beat and released by the owner's accepted eop beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else if (accept) begin
            if (accept_eop) begin
                state  <= IDLE;
                busy   <= 1'b0;
                rr_ptr <= next_id(sel_id);
            end else if (state == IDLE) begin
                state    <= LOCKED;
                busy     <= 1'b1;
                grant_id <= sel_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wen   <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            fifo_wen <= accept;
            if (accept) begin
                fifo_wdata <= req_data[sel_id];
            end
        end
    end

`ifdef NX_FIFO_WR_ARB_STATS_EN
    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (stats_clr) begin
            grant_cnt <= '0;
        end else if (accept_eop && (grant_cnt[sel_id] != '1)) begin
            grant_cnt[sel_id] <= grant_cnt[sel_id] + STAT_W'(1);
        end
    end
`endif

`ifdef NX_ASSERT
    for (genvar i = 0; i < N_REQ; i++) begin : g_hold_chk
        a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[i] && !req_ready[i]) |=>
                (!req_valid[i] || ($stable(req_data[i]) && $stable(req_eop[i]))));
    end
`endif

endmodule

// File: tb/tb_nx_cdc_fifo_wr_arb.sv
// Self-checking bench for nx_cdc_fifo_wr_arb: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_nx_cdc_fifo_wr_arb;

    localparam int N     = 4;
    localparam int W     = 64;
    localparam int DEPTH = 16;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int IW    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_eop   = '0;
    logic [N-1:0][W-1:0] req_data  = '0;
    logic [N-1:0]        req_ready;
    logic [FW-1:0]       fifo_free = FW'(DEPTH);
    logic                fifo_full = 1'b0;
    logic                fifo_wen;
    logic [W-1:0]        fifo_wdata;
    logic [IW-1:0]       grant_id;
    logic                busy;
`ifdef NX_FIFO_WR_ARB_STATS_EN
    logic                stats_clr = 1'b0;
    logic [N-1:0][15:0]  grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nx_cdc_fifo_wr_arb #(.N_REQ(N), .WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_eop    (req_eop),
        .req_ready  (req_ready),
        .fifo_free  (fifo_free),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef NX_FIFO_WR_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic int first_valid(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Behavioural model: owner (-1 when free), round-robin start, and the beat due on the FIFO port.
    int           m_owner = -1;
    int           m_rr    = 0;
    logic         m_wen   = 1'b0;
    logic [W-1:0] m_wdata = '0;
    logic [N-1:0] cmp_ready;
    logic         cmp_credit;
    int           cmp_win;
    int           grant_log[$];
    logic [W-1:0] wdata_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_rr    = 0;
            m_wen   = 1'b0;
            m_wdata = '0;
            check_output("rst_ready", req_ready, 0);
            check_output("rst_wen", fifo_wen, 0);
            check_output("rst_wdata", fifo_wdata, 0);
            check_output("rst_busy", busy, 0);
            check_output("rst_grant_id", grant_id, 0);
        end else begin
            cmp_credit = (int'(fifo_free) > (m_wen ? 1 : 0)) && !fifo_full;
            cmp_ready  = '0;
            cmp_win    = -1;
            if (m_owner < 0) begin
                if (cmp_credit) cmp_win = first_valid(req_valid, m_rr);
                if (cmp_win >= 0) cmp_ready[cmp_win] = 1'b1;
            end else begin
                cmp_ready[m_owner] = cmp_credit;
                if (cmp_credit) cmp_win = m_owner;
            end
            check_output("ready", req_ready, cmp_ready);
            check_output("wen", fifo_wen, m_wen);
            check_output("wdata", fifo_wdata, m_wdata);
            check_output("busy", busy, (m_owner >= 0) ? 1 : 0);
            if (m_owner >= 0) check_output("grant_id", grant_id, m_owner);
            if (fifo_wen === 1'b1) wdata_log.push_back(fifo_wdata);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
            end
            if (cmp_win >= 0 && req_valid[cmp_win]) begin
                m_wen   = 1'b1;
                m_wdata = req_data[cmp_win];
                if (req_eop[cmp_win]) begin
                    m_owner = -1;
                    m_rr    = (cmp_win + 1) % N;
                end else begin
                    m_owner = cmp_win;
                end
            end else begin
                m_wen = 1'b0;
            end
        end
    end

    logic [N-1:0] s_ready;
    logic [N-1:0] s_acc;
    logic         s_wen;
    bit           fifo_auto = 1'b0;
    bit           rand_req  = 1'b0;
    int           occ       = 0;
    int           rd_pct    = 50;
    int           left[N];

    // One clock: sample at the falling edge, then drive the next inputs just after the rising edge.
    task automatic apply_stimulus();
        @(negedge clk);
        s_ready = req_ready;
        s_wen   = fifo_wen;
        s_acc   = req_ready & req_valid;
        @(posedge clk);
        #1;
        if (fifo_auto) begin
            if (s_wen) begin
                check_output("no_overflow", (occ < DEPTH) ? 1 : 0, 1);
                occ++;
            end
            if (occ > 0 && $urandom_range(99) < rd_pct) occ--;
            fifo_free = FW'(DEPTH - occ);
            fifo_full = (occ == DEPTH);
        end
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (s_acc[i]) left[i]--;
                if (s_acc[i] || !req_valid[i]) begin
                    if ($urandom_range(3) != 0) begin
                        if (left[i] == 0) left[i] = $urandom_range(5, 1);
                        req_valid[i] = 1'b1;
                        req_data[i]  = {$urandom, $urandom};
                        req_eop[i]   = (left[i] == 1);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    int           wen_cnt;
    int           beat;
    int           exp_rr_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int           exp_t3_grants[5] = '{1, 1, 1, 1, 2};
    logic [W-1:0] exp_t3_data[5] = '{64'h1111_0000_0000_0000, 64'h1111_0000_0000_0001,
                                     64'h1111_0000_0000_0002, 64'h1111_0000_0000_0003,
                                     64'h2222_0000_0000_00AA};

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) apply_stimulus();
        rst_n = 1'b1;

        // Idle after reset release: nothing requested, nothing written.
        for (int c = 0; c < 5; c++) begin
            apply_stimulus();
            check_output("t1_ready", s_ready, 0);
            check_output("t1_wen", s_wen, 0);
        end
        check_output("t1_busy", busy, 0);

        // Every requester streams single-beat packets: strict rotation, one write per cycle.
        grant_log.delete();
        req_valid = '1;
        req_eop   = '1;
        for (int i = 0; i < N; i++) req_data[i] = {32'(i), $urandom};
        wen_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            apply_stimulus();
            if (c >= 1 && s_wen) wen_cnt++;
            for (int i = 0; i < N; i++) begin
                if (s_acc[i]) req_data[i] = {32'(i), $urandom};
            end
        end
        req_valid = '0;
        apply_stimulus();
        check_output("t2_wen_count", wen_cnt, 8);
        check_output("t2_grant_count", (grant_log.size() >= 8) ? 1 : 0, 1);
        for (int k = 0; k < 8; k++) begin
            check_output($sformatf("t2_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, exp_rr_seq[k]);
        end

        // Four-beat packet from req1 holds off req2 until its eop is taken.
        grant_log.delete();
        wdata_log.delete();
        beat = 0;
        req_valid[1] = 1'b1; req_data[1] = 64'h1111_0000_0000_0000; req_eop[1] = 1'b0;
        req_valid[2] = 1'b1; req_data[2] = 64'h2222_0000_0000_00AA; req_eop[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            apply_stimulus();
            if (s_acc[1]) begin
                beat++;
                if (beat == 4) begin
                    req_valid[1] = 1'b0;
                    req_eop[1]   = 1'b0;
                end else begin
                    req_data[1] = 64'h1111_0000_0000_0000 + 64'(beat);
                    req_eop[1]  = (beat == 3);
                end
            end
            if (s_acc[2]) req_valid[2] = 1'b0;
        end
        req_eop = '0;
        check_output("t3_grant_count", grant_log.size(), 5);
        check_output("t3_wdata_count", wdata_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("t3_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, exp_t3_grants[k]);
            check_output($sformatf("t3_wdata%0d", k), (k < wdata_log.size()) ? wdata_log[k] : '0, exp_t3_data[k]);
        end

        // One free slot: the in-flight beat consumes it until fifo_free is refreshed.
        req_valid[0] = 1'b1; req_data[0] = 64'h4444_0000_0000_0000; req_eop[0] = 1'b0;
        fifo_free = FW'(1);
        apply_stimulus();
        check_output("t4_first_ready", s_ready, 4'b0001);
        req_data[0] = 64'h4444_0000_0000_0001;
        apply_stimulus();
        check_output("t4_stall_inflight", s_ready, 0);
        check_output("t4_wen_inflight", s_wen, 1);
        fifo_free = FW'(0);
        apply_stimulus();
        check_output("t4_stall_landed", s_ready, 0);
        fifo_free = FW'(1);
        apply_stimulus();
        check_output("t4_refreshed", s_ready, 4'b0001);
        req_data[0] = 64'h4444_0000_0000_0002;
        req_eop[0]  = 1'b1;
        fifo_free   = FW'(DEPTH);
        apply_stimulus();
        check_output("t4_eop_accept", s_acc, 4'b0001);
        req_valid = '0;
        req_eop   = '0;
        apply_stimulus();

        // Randomized traffic with slow and fast FIFO drain phases.
        occ = 0;
        fifo_free = FW'(DEPTH);
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) left[i] = 0;
        fifo_auto = 1'b1;
        rand_req  = 1'b1;
        for (int p = 0; p < 4; p++) begin
            rd_pct = (p % 2 == 0) ? 20 : 90;
            repeat (600) apply_stimulus();
        end
        rand_req  = 1'b0;
        fifo_auto = 1'b0;
        req_valid = '0;
        req_eop   = '0;
        fifo_free = FW'(DEPTH);
        fifo_full = 1'b0;

        // Clean reset, then lock req2 and reset mid-packet.
        rst_n = 1'b0;
        apply_stimulus();
        rst_n = 1'b1;
        req_valid[2] = 1'b1; req_data[2] = 64'h5555_0000_0000_0000; req_eop[2] = 1'b0;
        apply_stimulus();
        req_data[2] = 64'h5555_0000_0000_0001;
        check_output("t5_locked_busy", busy, 1);
        check_output("t5_locked_gid", grant_id, 2);
        check_output("t5_locked_wen", fifo_wen, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("t5_async_busy", busy, 0);
        check_output("t5_async_wen", fifo_wen, 0);
        check_output("t5_async_ready", req_ready, 0);
        req_valid = '1;
        req_eop   = '1;
        for (int i = 0; i < N; i++) req_data[i] = {32'h6666_0000 + 32'(i), $urandom};
        apply_stimulus();
        rst_n = 1'b1;
        grant_log.delete();
        apply_stimulus();
        req_valid = '0;
        check_output("t5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        apply_stimulus();

`ifdef NX_FIFO_WR_ARB_STATS_EN
        stats_clr = 1'b1;
        apply_stimulus();
        stats_clr = 1'b0;
        check_output("t6_cleared", grant_cnt[0], 0);
        req_valid[3] = 1'b1; req_eop[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_data[3] = {32'h7777_0000, 32'(c)};
            apply_stimulus();
        end
        req_valid[3] = 1'b0;
        check_output("t6_cnt3", grant_cnt[3], 3);
        req_valid[3] = 1'b1;
        req_data[3]  = 64'h7777_0000_0000_00FF;
        stats_clr    = 1'b1;
        apply_stimulus();
        stats_clr    = 1'b0;
        req_valid[3] = 1'b0;
        req_eop[3]   = 1'b0;
        check_output("t6_clr_priority", grant_cnt[3], 0);
        apply_stimulus();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
